// File: rtl/ctrl_types_pkg.sv
// Shared controller types: operation codes, request front-end states and response status codes.
package ctrl_types_pkg;

   // Controller operation input encoding
   typedef enum logic [1:0] {
      NOOP   = 2'd0,
      READ   = 2'd1,
      UPSERT = 2'd2,
      DELETE = 2'd3
   } operation_e;

   // Request front-end states
   typedef enum logic [1:0] {
      IF_IDLE  = 2'd0,
      IF_ISSUE = 2'd1,
      IF_WAIT  = 2'd2,
      IF_RESP  = 2'd3
   } if_state_e;

   // Status returned to the host
   typedef enum logic [1:0] {
      RESP_OK      = 2'd0,
      RESP_ERR     = 2'd1,
      RESP_TIMEOUT = 2'd2,
      RESP_NOACK   = 2'd3
   } resp_status_e;

endpackage

// File: rtl/if_timeout_ctr.sv
// Saturating cycle counter that flags the cycle whose increment reaches TIMEOUT_CYCLES.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   clear_i       zero the counter (wins over enable_i)
//   enable_i      count this cycle
//   expired_c_o   combinational: counting this cycle reaches TIMEOUT_CYCLES
module if_timeout_ctr #(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic expired_c_o
);

   localparam int unsigned     CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   // Next count: clear has priority, saturate at the limit
   always_comb begin
      count_d = count_q;
      if (clear_i) begin
         count_d = '0;
      end else if (enable_i && (count_q != LIMIT)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // This cycle's increment lands on TIMEOUT_CYCLES
   assign expired_c_o = enable_i && (count_q >= LAST);

endmodule

// File: rtl/cache_req_if.sv
// Host-facing request front end of the key/value cache controller.
// Accepts one op/key/value request, issues it to the controller, waits for
// completion (or times out) and returns a registered status/value to the host.
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   req_valid_i/req_ready_o          host request handshake
//   req_op_i, req_key_i, req_value_i request payload
//   resp_valid_o/resp_ready_i        host response handshake
//   resp_status_o, resp_value_o      response payload (value only for READ+OK)
//   ctrl_operation_o, ctrl_key_o,
//   ctrl_value_o                     controller command outputs
//   ctrl_busy_i, ctrl_busy_valid_i,
//   ctrl_op_valid_i,
//   ctrl_data_valid_i, ctrl_rdata_i  controller status/data inputs
module cache_req_if
   import ctrl_types_pkg::*;
#(
   parameter int unsigned KEY_WIDTH      = 16,
   parameter int unsigned VAL_WIDTH      = 32,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  operation_e           req_op_i,
   input  logic [KEY_WIDTH-1:0] req_key_i,
   input  logic [VAL_WIDTH-1:0] req_value_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [1:0]           resp_status_o,
   output logic [VAL_WIDTH-1:0] resp_value_o,
   output operation_e           ctrl_operation_o,
   output logic [KEY_WIDTH-1:0] ctrl_key_o,
   output logic [VAL_WIDTH-1:0] ctrl_value_o,
   input  logic                 ctrl_busy_i,
   input  logic                 ctrl_busy_valid_i,
   input  logic                 ctrl_op_valid_i,
   input  logic                 ctrl_data_valid_i,
   input  logic [VAL_WIDTH-1:0] ctrl_rdata_i
);

   if_state_e            state_q;
   operation_e           op_q;
   logic [KEY_WIDTH-1:0] key_q;
   logic [VAL_WIDTH-1:0] value_q;
   logic                 resp_valid_q;
   resp_status_e         resp_status_q;
   logic [VAL_WIDTH-1:0] resp_value_q;

   logic ack_c;
   logic done_c;
   logic ctr_clear_c;
   logic ctr_en_c;
   logic expired_c;

   // Controller has taken the op / has returned to idle with the op finished
   assign ack_c  = ctrl_busy_valid_i && ctrl_busy_i;
   assign done_c = ctrl_op_valid_i && ctrl_busy_valid_i && !ctrl_busy_i;

   // Counter restarts on entry to ISSUE and to WAIT; runs while waiting in either
   assign ctr_clear_c = (state_q == IF_IDLE) || ((state_q == IF_ISSUE) && ack_c);
   assign ctr_en_c    = ((state_q == IF_ISSUE) && !ack_c) ||
                        ((state_q == IF_WAIT) && !done_c);

   if_timeout_ctr #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (ctr_clear_c),
      .enable_i   (ctr_en_c),
      .expired_c_o(expired_c)
   );

   // Request/response FSM with registered response payload
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= IF_IDLE;
         op_q          <= NOOP;
         key_q         <= '0;
         value_q       <= '0;
         resp_valid_q  <= 1'b0;
         resp_status_q <= RESP_OK;
         resp_value_q  <= '0;
      end else begin
         unique case (state_q)
            IF_IDLE: begin
               if (req_valid_i) begin
                  op_q    <= req_op_i;
                  key_q   <= req_key_i;
                  value_q <= req_value_i;
                  if (req_op_i == NOOP) begin
                     state_q       <= IF_RESP;
                     resp_valid_q  <= 1'b1;
                     resp_status_q <= RESP_OK;
                     resp_value_q  <= '0;
                  end else begin
                     state_q <= IF_ISSUE;
                  end
               end
            end
            IF_ISSUE: begin
               if (ack_c) begin
                  state_q <= IF_WAIT;
               end else if (expired_c) begin
                  state_q       <= IF_RESP;
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= RESP_NOACK;
                  resp_value_q  <= '0;
               end
            end
            IF_WAIT: begin
               // Completion takes priority over a coincident timeout
               if (done_c) begin
                  state_q      <= IF_RESP;
                  resp_valid_q <= 1'b1;
                  if (op_q == READ) begin
                     resp_status_q <= ctrl_data_valid_i ? RESP_OK : RESP_ERR;
                     resp_value_q  <= ctrl_data_valid_i ? ctrl_rdata_i : '0;
                  end else begin
                     resp_status_q <= RESP_OK;
                     resp_value_q  <= '0;
                  end
               end else if (expired_c) begin
                  state_q       <= IF_RESP;
                  resp_valid_q  <= 1'b1;
                  resp_status_q <= RESP_TIMEOUT;
                  resp_value_q  <= '0;
               end
            end
            IF_RESP: begin
               if (resp_ready_i) begin
                  state_q       <= IF_IDLE;
                  resp_valid_q  <= 1'b0;
                  resp_status_q <= RESP_OK;
                  resp_value_q  <= '0;
               end
            end
            default: begin
               state_q <= IF_IDLE;
            end
         endcase
      end
   end

   // Op is presented only while issuing so the controller is not re-triggered
   assign ctrl_operation_o = (state_q == IF_ISSUE) ? op_q : NOOP;
   assign req_ready_o      = (state_q == IF_IDLE);
   assign resp_valid_o     = resp_valid_q;
   assign resp_status_o    = resp_status_q;
   assign resp_value_o     = resp_value_q;
   assign ctrl_key_o       = key_q;
   assign ctrl_value_o     = value_q;

endmodule

// File: tb/tb_cache_req_if.sv
// Directed bench for cache_req_if: a transaction-level timing model predicts every
// output for every cycle of each transaction; a negedge process compares.
module tb_cache_req_if;
   import ctrl_types_pkg::*;

   localparam int unsigned KW = 16;
   localparam int unsigned VW = 32;
   localparam int          TO = 64;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_valid;
   logic          req_ready_o;
   operation_e    req_op;
   logic [KW-1:0] req_key;
   logic [VW-1:0] req_value;
   logic          resp_valid_o;
   logic          resp_ready;
   logic [1:0]    resp_status_o;
   logic [VW-1:0] resp_value_o;
   operation_e    ctrl_operation_o;
   logic [KW-1:0] ctrl_key_o;
   logic [VW-1:0] ctrl_value_o;
   logic          busy;
   logic          busy_valid;
   logic          op_valid;
   logic          data_valid;
   logic [VW-1:0] rdata;

   always #5 clk = ~clk;

   cache_req_if #(
      .KEY_WIDTH(KW), .VAL_WIDTH(VW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid), .req_ready_o(req_ready_o),
      .req_op_i(req_op), .req_key_i(req_key), .req_value_i(req_value),
      .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready),
      .resp_status_o(resp_status_o), .resp_value_o(resp_value_o),
      .ctrl_operation_o(ctrl_operation_o), .ctrl_key_o(ctrl_key_o), .ctrl_value_o(ctrl_value_o),
      .ctrl_busy_i(busy), .ctrl_busy_valid_i(busy_valid), .ctrl_op_valid_i(op_valid),
      .ctrl_data_valid_i(data_valid), .ctrl_rdata_i(rdata)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Expected outputs for the current cycle, written by the stimulus task
   logic          chk_en = 1'b0;
   logic          e_req_ready;
   logic          e_resp_valid;
   logic [1:0]    e_status;
   logic [VW-1:0] e_value;
   operation_e    e_op;
   logic [KW-1:0] e_key;
   logic [VW-1:0] e_val;
   logic [KW-1:0] last_key = '0;
   logic [VW-1:0] last_val = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready",  64'(req_ready_o),      64'(e_req_ready));
         chk("resp_valid", 64'(resp_valid_o),     64'(e_resp_valid));
         chk("resp_status",64'(resp_status_o),    64'(e_status));
         chk("resp_value", 64'(resp_value_o),     64'(e_value));
         chk("ctrl_op",    64'(ctrl_operation_o), 64'(e_op));
         chk("ctrl_key",   64'(ctrl_key_o),       64'(e_key));
         chk("ctrl_value", 64'(ctrl_value_o),     64'(e_val));
      end
   end

   // One transaction. Cycle t=0 is the accept cycle; controller events are given
   // as cycle offsets (0 = never). Timing rules: op on ctrl for t=1..ack; WAIT
   // from ack+1; completion at d gives response at d+1; no ack within TO cycles
   // gives NOACK at TO+1; no completion within TO wait cycles gives TIMEOUT.
   task automatic run_txn(input operation_e op, input logic [KW-1:0] key, input logic [VW-1:0] val,
                          input int ack_t, input int done_t, input logic dv, input logic [VW-1:0] rd,
                          input int glitch_t, input int hold,
                          output int first_resp, output logic [VW-1:0] first_val);
      int            issue_end;
      int            r;
      logic [1:0]    st;
      logic [VW-1:0] rv;
      rv = '0;
      if (op == NOOP) begin
         issue_end = 0; r = 1; st = RESP_OK;
      end else if (ack_t >= 1 && ack_t <= TO) begin
         issue_end = ack_t;
         if (done_t > ack_t && done_t <= ack_t + TO) begin
            r = done_t + 1;
            if (op == READ) begin
               st = dv ? RESP_OK : RESP_ERR;
               rv = dv ? rd : '0;
            end else begin
               st = RESP_OK;
            end
         end else begin
            r = ack_t + TO + 1; st = RESP_TIMEOUT;
         end
      end else begin
         issue_end = TO; r = TO + 1; st = RESP_NOACK;
      end
      first_resp = -1;
      first_val  = '0;
      chk_en = 1'b1;
      for (int t = 0; t <= r + hold + 1; t++) begin
         // host side; a junk request is offered during the response handshake
         req_valid  = (t == 0) || (t == r + hold);
         req_op     = (t == 0) ? op : operation_e'(2'($urandom_range(0, 3)));
         req_key    = (t == 0) ? key : KW'($urandom);
         req_value  = (t == 0) ? val : VW'($urandom);
         resp_ready = (t == r + hold) || (t < r && (t % 2) == 1);
         // controller side
         busy_valid = 1'b0; busy = 1'b0; op_valid = 1'b0; data_valid = 1'b0;
         rdata      = VW'($urandom);
         if (op != NOOP && ack_t > 0) begin
            if (t >= ack_t && (done_t == 0 || t < done_t)) begin
               busy_valid = 1'b1; busy = 1'b1;
            end
            if (t == glitch_t) data_valid = 1'b1;
            if (t == done_t) begin
               busy_valid = 1'b1; busy = 1'b0; op_valid = 1'b1;
               data_valid = dv; rdata = rd;
            end
         end
         // expected outputs
         e_req_ready  = (t == 0) || (t == r + hold + 1);
         e_resp_valid = (t >= r) && (t <= r + hold);
         e_status     = e_resp_valid ? st : RESP_OK;
         e_value      = e_resp_valid ? rv : '0;
         e_op         = (t >= 1 && t <= issue_end) ? op : NOOP;
         e_key        = (t == 0) ? last_key : key;
         e_val        = (t == 0) ? last_val : val;
         @(negedge clk);
         if (resp_valid_o && first_resp < 0) begin
            first_resp = t;
            first_val  = resp_value_o;
         end
         @(posedge clk);
         #1;
      end
      chk_en     = 1'b0;
      last_key   = key;
      last_val   = val;
      req_valid  = 1'b0;
      resp_ready = 1'b0;
      busy_valid = 1'b0; busy = 1'b0; op_valid = 1'b0; data_valid = 1'b0;
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_resp_valid"}, 64'(resp_valid_o),     64'(0));
      chk({tag, "_req_ready"},  64'(req_ready_o),      64'(1));
      chk({tag, "_status"},     64'(resp_status_o),    64'(RESP_OK));
      chk({tag, "_value"},      64'(resp_value_o),     64'(0));
      chk({tag, "_op"},         64'(ctrl_operation_o), 64'(NOOP));
      chk({tag, "_key"},        64'(ctrl_key_o),       64'(0));
      chk({tag, "_cval"},       64'(ctrl_value_o),     64'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int            fr;
      logic [VW-1:0] fv;
      rst = 1'b1; req_valid = 1'b0; req_op = NOOP; req_key = '0; req_value = '0;
      resp_ready = 1'b0; busy = 1'b0; busy_valid = 1'b0; op_valid = 1'b0;
      data_valid = 1'b0; rdata = '0;
      #2;
      chk_reset_outputs("reset");
      @(posedge clk); @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;

      // UPSERT: ack at t=1, completion 3 cycles later
      run_txn(UPSERT, 16'h0012, 32'hDEADBEEF, 1, 4, 1'b0, '0, 0, 0, fr, fv);
      chk("upsert_latency", 64'(fr), 64'(5));
      // READ hit
      run_txn(READ, 16'h0012, 32'h0, 1, 3, 1'b1, 32'hDEADBEEF, 0, 0, fr, fv);
      chk("read_latency", 64'(fr), 64'(4));
      chk("read_value", 64'(fv), 64'(32'hDEADBEEF));
      // READ miss: ack then silence, stray data_valid ignored
      run_txn(READ, 16'h0034, 32'h0, 2, 0, 1'b0, '0, 10, 0, fr, fv);
      chk("read_timeout_latency", 64'(fr), 64'(67));
      // DELETE never acked
      run_txn(DELETE, 16'h0056, 32'h0, 0, 0, 1'b0, '0, 0, 0, fr, fv);
      chk("delete_noack_latency", 64'(fr), 64'(65));
      // NOOP never reaches the controller
      run_txn(NOOP, 16'h0077, 32'h55AA55AA, 0, 0, 1'b0, '0, 0, 0, fr, fv);
      chk("noop_latency", 64'(fr), 64'(1));
      // Host back-pressure for 10 cycles
      run_txn(UPSERT, 16'h0101, 32'hCAFEF00D, 1, 3, 1'b0, '0, 0, 10, fr, fv);
      // READ completion without data -> ERR
      run_txn(READ, 16'h0202, 32'h0, 1, 2, 1'b0, 32'h12345678, 0, 0, fr, fv);
      // Completion on the expiring wait cycle -> OK with data
      run_txn(READ, 16'h0303, 32'h0, 1, 65, 1'b1, 32'hA5A5_0F0F, 0, 2, fr, fv);
      chk("edge_latency", 64'(fr), 64'(66));
      chk("edge_value", 64'(fv), 64'(32'hA5A5_0F0F));

      // Reset mid-WAIT
      req_valid = 1'b1; req_op = UPSERT; req_key = 16'h00AB; req_value = 32'h1234_5678;
      @(posedge clk); #1;
      req_valid = 1'b0; busy_valid = 1'b1; busy = 1'b1;
      chk("pre_rst_issue_op", 64'(ctrl_operation_o), 64'(UPSERT));
      @(posedge clk); #1;
      chk("pre_rst_wait_op", 64'(ctrl_operation_o), 64'(NOOP));
      chk("pre_rst_wait_key", 64'(ctrl_key_o), 64'(16'h00AB));
      @(posedge clk); #2 rst = 1'b1; #1;
      chk_reset_outputs("rst_wait");
      busy_valid = 1'b0; busy = 1'b0;
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;

      // Reset mid-ISSUE drops the op immediately
      req_valid = 1'b1; req_op = READ; req_key = 16'h00CD; req_value = 32'h0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      chk("pre_rst2_issue_op", 64'(ctrl_operation_o), 64'(READ));
      #2 rst = 1'b1; #1;
      chk_reset_outputs("rst_issue");
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;
      last_key = '0;
      last_val = '0;

      // Normal operation after reset
      run_txn(UPSERT, 16'h0EEE, 32'h0BAD_CAFE, 1, 4, 1'b0, '0, 0, 0, fr, fv);
      chk("post_rst_latency", 64'(fr), 64'(5));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
